// File: rtl/his_readout_fsm_pkg.sv
// Shared histogram geometry and readout state encoding, common to the
// histogram builder and the readout engine.
package his_pkg;

  localparam int BIN_NUM   = 64;
  localparam int BIN_W     = $clog2(BIN_NUM);
  localparam int PIXEL_NUM = 200;
  localparam int PIX_W     = 8;
  localparam int CNT_W     = 8;
  localparam int ADDR_W    = 14;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_OUT  = 3'd3,
    ST_PEAK = 3'd4,
    ST_DONE = 3'd5
  } his_rd_state_t;

endpackage

// File: rtl/his_readout_fsm_peak_tracker.sv
// Running maximum over one pixel's bins; ties keep the earliest (lowest) bin
// because a later bin must be strictly larger to replace the current peak.
module his_peak_tracker #(
  parameter int BIN_W = his_pkg::BIN_W,
  parameter int CNT_W = his_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             res,
  input  logic             clr,
  input  logic             ld,
  input  logic [BIN_W-1:0] bin,
  input  logic [CNT_W-1:0] count,
  output logic [BIN_W-1:0] pk_bin,
  output logic [CNT_W-1:0] pk_count
);

  logic take;

  // Bin 0 seeds the tracker so an all-zero histogram still reports bin 0.
  assign take = ld & ((bin == '0) | (count > pk_count));

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      pk_bin   <= '0;
      pk_count <= '0;
    end else if (clr) begin
      pk_bin   <= '0;
      pk_count <= '0;
    end else if (take) begin
      pk_bin   <= bin;
      pk_count <= count;
    end
  end

endmodule

// File: rtl/his_readout_fsm.sv
// Histogram readout engine: walks a completed histogram bank bin by bin,
// streams every count on valid/ready and reports each pixel's peak bin.
module his_readout_fsm #(
  parameter int BIN_NUM   = his_pkg::BIN_NUM,
  parameter int BIN_W     = his_pkg::BIN_W,
  parameter int PIXEL_NUM = his_pkg::PIXEL_NUM,
  parameter int PIX_W     = his_pkg::PIX_W,
  parameter int CNT_W     = his_pkg::CNT_W,
  parameter int ADDR_W    = his_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic              bank,
  output logic              rd_en,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [CNT_W-1:0]  rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [PIX_W-1:0]  m_pixel,
  output logic [BIN_W-1:0]  m_bin,
  output logic [CNT_W-1:0]  m_count,
  output logic              m_last_bin,
  output logic              m_last,
  output logic              pk_valid,
  output logic [PIX_W-1:0]  pk_pixel,
  output logic [BIN_W-1:0]  pk_bin,
  output logic [CNT_W-1:0]  pk_count,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  import his_pkg::*;

  his_rd_state_t    state;
  his_rd_state_t    state_nxt;
  logic [PIX_W-1:0] pixel;
  logic [BIN_W-1:0] bin;
  logic             last_bin;
  logic             last_pix;
  logic             hs;
  logic [BIN_W-1:0] trk_bin;
  logic [CNT_W-1:0] trk_count;

  // Address is formed at full ADDR_W width so the product never truncates.
  function automatic logic [ADDR_W-1:0] calc_addr(input logic [PIX_W-1:0] pix,
                                                  input logic [BIN_W-1:0] b);
    return ADDR_W'(pix) * ADDR_W'(BIN_NUM) + ADDR_W'(b);
  endfunction

  assign last_bin = (bin == BIN_W'(BIN_NUM - 1));
  assign last_pix = (pixel == PIX_W'(PIXEL_NUM - 1));
  assign hs       = (state == ST_OUT) & m_valid & m_ready;

  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign rd_en    = (state == ST_RD);
  assign rd_addr  = rd_en ? calc_addr(pixel, bin) : '0;

  // Peak outputs are only meaningful during the PEAK cycle; zero otherwise.
  assign pk_valid = (state == ST_PEAK);
  assign pk_pixel = pk_valid ? pixel     : '0;
  assign pk_bin   = pk_valid ? trk_bin   : '0;
  assign pk_count = pk_valid ? trk_count : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RD;
      ST_RD:   state_nxt = ST_CAP;
      ST_CAP:  state_nxt = ST_OUT;
      ST_OUT:  if (hs) state_nxt = last_bin ? ST_PEAK : ST_RD;
      ST_PEAK: state_nxt = last_pix ? ST_DONE : ST_RD;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control: state, walk counters, bank latch, overrun flag.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state   <= ST_IDLE;
      pixel   <= '0;
      bin     <= '0;
      rd_bank <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      overrun <= start & busy;
      case (state)
        ST_IDLE: begin
          if (start) begin
            rd_bank <= bank;
            pixel   <= '0;
            bin     <= '0;
          end
        end
        ST_OUT: begin
          if (hs && !last_bin) bin <= bin + 1'b1;
        end
        ST_PEAK: begin
          if (!last_pix) begin
            pixel <= pixel + 1'b1;
            bin   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Stream stage: capture the read data one cycle after the read strobe and
  // hold it until the downstream handshake.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      m_valid    <= 1'b0;
      m_pixel    <= '0;
      m_bin      <= '0;
      m_count    <= '0;
      m_last_bin <= 1'b0;
      m_last     <= 1'b0;
    end else if (state == ST_CAP) begin
      m_valid    <= 1'b1;
      m_pixel    <= pixel;
      m_bin      <= bin;
      m_count    <= rd_data;
      m_last_bin <= last_bin;
      m_last     <= last_bin & last_pix;
    end else if (hs) begin
      m_valid    <= 1'b0;
    end
  end

  his_peak_tracker #(
    .BIN_W (BIN_W),
    .CNT_W (CNT_W)
  ) u_peak (
    .clk      (clk),
    .res      (res),
    .clr      (pk_valid),
    .ld       (hs),
    .bin      (m_bin),
    .count    (m_count),
    .pk_bin   (trk_bin),
    .pk_count (trk_count)
  );

endmodule

// File: doc/his_readout_fsm.md
# his_readout_fsm

Histogram readout engine for the dToF SPAD histogram RAM. On the builder's acquisition-finished pulse it takes the just-completed bank, then walks every pixel's bins in ascending address order through a one-cycle-latency read port. It streams each bin count out on a valid/ready interface and reports one peak (maximum bin) per pixel. It sits between the histogram builder's ping-pong RAM and the downstream depth/peak processing.

## Interface
- BIN_NUM, 64, bins per pixel histogram (power of two)
- BIN_W, 6, log2(BIN_NUM)
- PIXEL_NUM, 200, pixels per RAM
- PIX_W, 8, pixel index width
- CNT_W, 8, bin count width (matches builder peakMax)
- ADDR_W, 14, RAM address width, ≥ ceil(log2(PIXEL_NUM*BIN_NUM))
- clk  in  1  single clock, rising edge
- res  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse from builder (acquisition finished)
- bank  in  1  completed bank index (builder hisNum), sampled with start
- rd_en  out  1  RAM read strobe
- rd_bank  out  1  bank being read
- rd_addr  out  ADDR_W  pixel*BIN_NUM + bin
- rd_data  in  CNT_W  read data, valid the cycle after rd_en
- m_valid  out  1  stream data valid
- m_ready  in  1  downstream accepts
- m_pixel  out  PIX_W  pixel of current beat
- m_bin  out  BIN_W  bin of current beat
- m_count  out  CNT_W  bin count
- m_last_bin  out  1  beat is bin BIN_NUM-1
- m_last  out  1  beat is last bin of last pixel
- pk_valid  out  1  one-cycle pulse, peak result valid
- pk_pixel / pk_bin / pk_count  out  PIX_W / BIN_W / CNT_W  peak result
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, frame read complete
- overrun  out  1  one-cycle pulse, start received while busy

## Operation
- States: IDLE, RD, CAP, OUT, PEAK, DONE.
- IDLE: on start=1, latch bank into rd_bank, pixel=0, bin=0, go to RD.
- RD: rd_en=1 (decoded from state), rd_addr from pixel/bin counters; go to CAP.
- CAP: register rd_data into m_count with m_pixel/m_bin/flags; set m_valid; go to OUT.
- OUT: hold all m_* stable while m_valid & ~m_ready. On handshake: clear m_valid, update peak tracker, then:
  - bin < BIN_NUM-1: bin+1, go to RD.
  - else go to PEAK.
- PEAK: pk_valid=1 for one cycle with the latched peak; reset tracker; if pixel < PIXEL_NUM-1 then pixel+1, bin=0, go to RD; else go to DONE.
- DONE: done=1 one cycle, go to IDLE.
- Peak rule: bin 0 loads the tracker unconditionally; a later bin replaces it only if count is strictly greater, so ties keep the lowest bin. An all-zero histogram reports bin 0, count 0.
- start while busy: ignored, overrun=1 next cycle, current frame unaffected. rd_bank is not changed.
- Counter wrap: bin and pixel never exceed BIN_NUM-1 and PIXEL_NUM-1; rd_addr is computed at ADDR_W width with no truncation.
- Reset (any time, including mid-frame): state IDLE; all outputs 0 (rd_en, rd_bank, rd_addr, m_*, pk_*, busy, done, overrun); counters and tracker cleared. The next start begins a fresh frame.

## Timing
- start sampled at edge E0. rd_en=1 in cycle E0..E1 with addr 0. m_valid rises after E2.
- Minimum 3 cycles per bin (RD, CAP, OUT with m_ready held high). Add 1 PEAK cycle per pixel and 1 DONE cycle per frame.
- Full frame with m_ready=1: PIXEL_NUM*(3*BIN_NUM+1)+1 cycles from E0 to the done pulse.
- pk_valid follows the last-bin handshake of its pixel by exactly 1 cycle.
- done follows the final pk_valid by exactly 1 cycle. busy falls on the same edge that ends DONE.
- rd_en is never asserted outside RD. There is at most one outstanding read.

## Structure
- Shared package his_pkg: BIN_NUM, PIXEL_NUM, CNT_W, and the derived widths, shared with the builder; state enum his_rd_state_t.
- Sub-module his_peak_tracker: inputs clk, res, clr, ld, bin, count; outputs pk_bin, pk_count; implements the strict-greater rule.

## Test plan
- Test build uses PIXEL_NUM=2, BIN_NUM=4. Pixel 0 holds {3,7,7,1}, pixel 1 holds {0,0,0,0}, m_ready=1. Required: 8 beats in address order. Pixel 0 peak is bin 1, count 7 (tie keeps the lower bin). Pixel 1 peak is bin 0, count 0. done arrives 2*(13)+1=27 cycles after start.
- Same data, m_ready toggling 1/0 randomly: identical beat sequence; m_* stay stable while stalled; no extra rd_en.
- start with bank=1, then builder drives hisNum=0 mid-frame: rd_bank stays 1 for the whole frame.
- Second start pulse at cycle 5 of a frame: overrun pulses once, and the frame completes unchanged with 8 beats.
- res low during pixel 1 bin 2: all outputs 0 immediately. After release, a new start yields a complete frame from pixel 0 bin 0.
- Full-scale count 255 in bin 3 of pixel 0: pk_count=255 and pk_bin=3, with no overflow or wrap.
